// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined RV32I control unit.
// Holds the control-word layout carried through the E/M/W registers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  br_cond;
        alu_ctrl_t   alu_control;
        logic        alu_src;
        logic        pc_target_src;
    } ctrl_word_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
    } mem_word_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
    } wb_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decode into a control word.
// Unsupported or disabled encodings collapse to a NOP with illegal set.
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter bit EN_EXT_BRANCH = 1'b1,
    parameter bit EN_SHIFT      = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output ctrl_word_t ctrl_o,
    output imm_src_t   imm_src_o,
    output logic       illegal_o
);

    ctrl_word_t cw;
    imm_src_t   imm;
    logic       ill;

    // Raw decode per opcode class; illegality is folded in afterwards
    always_comb begin
        cw  = CTRL_NOP;
        imm = IMM_I;
        ill = 1'b0;
        unique case (opcode_i)
            OP_LOAD: begin
                cw.reg_write  = 1'b1;
                cw.alu_src    = 1'b1;
                cw.result_src = RES_MEM;
                ill           = (funct3_i != 3'b010);
            end
            OP_STORE: begin
                cw.mem_write = 1'b1;
                cw.alu_src   = 1'b1;
                imm          = IMM_S;
                ill          = (funct3_i != 3'b010);
            end
            OP_R, OP_I: begin
                cw.reg_write = 1'b1;
                cw.alu_src   = ~opcode_i[5];
                unique case (funct3_i)
                    3'b000: cw.alu_control =
                        (opcode_i[5] & funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        cw.alu_control = ALU_SLL;
                        ill            = ~EN_SHIFT;
                    end
                    3'b010: cw.alu_control = ALU_SLT;
                    3'b011: cw.alu_control = ALU_SLTU;
                    3'b100: cw.alu_control = ALU_XOR;
                    3'b101: begin
                        cw.alu_control =
                            funct7_5_i ? ALU_SRA : ALU_SRL;
                        ill            = ~EN_SHIFT;
                    end
                    3'b110: cw.alu_control = ALU_OR;
                    default: cw.alu_control = ALU_AND;
                endcase
            end
            OP_BRANCH: begin
                cw.branch      = 1'b1;
                cw.alu_control = ALU_SUB;
                cw.br_cond     = funct3_i;
                imm            = IMM_B;
                unique case (funct3_i)
                    F3_BEQ: ill = 1'b0;
                    F3_BNE, F3_BLT, F3_BGE,
                    F3_BLTU, F3_BGEU: ill = ~EN_EXT_BRANCH;
                    default: ill = 1'b1;
                endcase
            end
            OP_JAL: begin
                cw.jump       = 1'b1;
                cw.reg_write  = 1'b1;
                cw.result_src = RES_PC4;
                imm           = IMM_J;
            end
            OP_JALR: begin
                cw.jump          = 1'b1;
                cw.reg_write     = 1'b1;
                cw.alu_src       = 1'b1;
                cw.result_src    = RES_PC4;
                cw.pc_target_src = 1'b1;
                ill              = (funct3_i != 3'b000);
            end
            OP_LUI: begin
                cw.reg_write  = 1'b1;
                cw.result_src = RES_IMM;
                imm           = IMM_U;
            end
            default: ill = 1'b1;
        endcase
    end

    // Illegal encodings present a clean NOP downstream
    always_comb begin
        ctrl_o    = ill ? CTRL_NOP : cw;
        imm_src_o = ill ? IMM_I : imm;
        illegal_o = ill;
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decode, E/M/W control registers and
// Execute-stage branch/jump resolution with hazard-unit flush.
module pipe_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W    = 4,
    parameter bit EN_EXT_BRANCH = 1'b1,
    parameter bit EN_SHIFT      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode_d,
    input  logic [2:0]            funct3_d,
    input  logic                  funct7_5_d,
    input  logic                  flush_e,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [2:0]            imm_src_d,
    output logic                  illegal_d,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_e,
    output logic                  pc_src_e,
    output logic                  pc_target_src_e,
    output logic [1:0]            result_src_e,
    output logic                  reg_write_m,
    output logic                  mem_write_m,
    output logic [1:0]            result_src_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w
);

    if (ALU_CTRL_W < 4) begin : g_bad_width
        $error("ALU_CTRL_W must be at least 4");
    end

    ctrl_word_t dec_cw;
    imm_src_t   dec_imm;
    ctrl_word_t ex_q, ex_d;
    mem_word_t  mem_q, mem_d;
    wb_word_t   wb_q, wb_d;
    logic       take;

    instr_decoder #(
        .EN_EXT_BRANCH(EN_EXT_BRANCH),
        .EN_SHIFT     (EN_SHIFT)
    ) u_dec (
        .opcode_i  (opcode_d),
        .funct3_i  (funct3_d),
        .funct7_5_i(funct7_5_d),
        .ctrl_o    (dec_cw),
        .imm_src_o (dec_imm),
        .illegal_o (illegal_d)
    );

    // Next-state for E/M/W; flush injects a bubble into Execute only
    always_comb begin
        ex_d  = flush_e ? CTRL_NOP : dec_cw;
        mem_d = '{reg_write:  ex_q.reg_write,
                  result_src: ex_q.result_src,
                  mem_write:  ex_q.mem_write};
        wb_d  = '{reg_write:  mem_q.reg_write,
                  result_src: mem_q.result_src};
    end

    // Pipeline registers, cleared asynchronously so writes drop at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= CTRL_NOP;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Branch condition evaluated on the flags of the Execute instruction
    always_comb begin
        take = 1'b0;
        unique case (ex_q.br_cond)
            F3_BEQ:  take = zero_e;
            F3_BNE:  take = ~zero_e;
            F3_BLT:  take = lt_e;
            F3_BGE:  take = ~lt_e;
            F3_BLTU: take = ltu_e;
            F3_BGEU: take = ~ltu_e;
            default: take = 1'b0;
        endcase
    end

    assign pc_src_e        = ex_q.jump | (ex_q.branch & take);
    assign imm_src_d       = dec_imm;
    assign alu_control_e   = ALU_CTRL_W'(ex_q.alu_control);
    assign alu_src_e       = ex_q.alu_src;
    assign pc_target_src_e = ex_q.pc_target_src;
    assign result_src_e    = ex_q.result_src;
    assign reg_write_m     = mem_q.reg_write;
    assign mem_write_m     = mem_q.mem_write;
    assign result_src_m    = mem_q.result_src;
    assign reg_write_w     = wb_q.reg_write;
    assign result_src_w    = wb_q.result_src;

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined RV32I control unit for the 5-stage core. It decodes the instruction in Decode and carries the control word through the Execute, Memory and Writeback pipeline registers, and it resolves branches and jumps in Execute. Compared with the single-cycle decoder pair, it:
- widens ALU control;
- adds bne/blt/bge/bltu/bgeu, shifts, xor, slt/sltu, lui and jalr, each gated by a parameter;
- flags illegal opcodes instead of driving X;
- supports an Execute-stage flush driven by the hazard unit.

## Interface
Parameters:
- ALU_CTRL_W, 4, width of alu_control_e; values below 4 are rejected at elaboration, and bits above [3:0] are driven 0.
- EN_EXT_BRANCH, 1, enables bne/blt/bge/bltu/bgeu; when 0, those funct3 values decode as illegal.
- EN_SHIFT, 1, enables sll/srl/sra/slli/srli/srai; when 0, they decode as illegal.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode_d  in  7  instr[6:0] in Decode.
- funct3_d  in  3  instr[14:12].
- funct7_5_d  in  1  instr[30].
- flush_e  in  1  from the hazard unit; loads a bubble into the Execute register.
- zero_e, lt_e, ltu_e  in  1 each  ALU flags for rs1-rs2: equal, signed less-than, unsigned less-than.
- imm_src_d  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- illegal_d  out  1  unsupported opcode/funct in Decode.
- alu_control_e  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
- alu_src_e  out  1  1 = immediate operand B.
- pc_src_e  out  1  redirect the PC.
- pc_target_src_e  out  1  0 = PC+imm, 1 = ALU result (jalr).
- result_src_e  out  2  consumed by the hazard unit for load-use detection.
- reg_write_m, mem_write_m  out  1 each.
- result_src_m  out  2.
- reg_write_w  out  1.
- result_src_w  out  2  0 ALU, 1 memory, 2 PC+4, 3 immediate (lui).

## Operation
Decode (combinational):
- lw: reg_write=1, alu_src=1, result_src=1, imm I, ALU add.
- sw: mem_write=1, alu_src=1, imm S, ALU add.
- R-type (0110011): reg_write=1, ALU op from funct3/funct7_5.
- I-ALU (0010011): reg_write=1, alu_src=1, imm I.
  - funct3=000 is always add; sub is produced only when opcode[5]=1 and funct7_5=1.
  - For shifts, funct7_5 selects sra/srai over srl/srli in both R and I forms.
- Branch (1100011): branch=1, imm B, ALU sub. The funct3 value is stored as br_cond.
- jal: jump=1, reg_write=1, result_src=2, imm J.
- jalr: jump=1, reg_write=1, alu_src=1, result_src=2, pc_target_src=1, imm I, ALU add.
- lui: reg_write=1, result_src=3, imm U.
- Any other opcode/funct, or a disabled feature: the whole control word is 0 (a NOP) and illegal_d=1. X is never driven.

Pipeline:
- The Execute register captures {reg_write, result_src, mem_write, jump, branch, br_cond, alu_control, alu_src, pc_target_src} every cycle.
- The Memory register captures {reg_write, result_src, mem_write} from Execute.
- The Writeback register captures {reg_write, result_src} from Memory.
- There is no stall on Execute, Memory or Writeback; stalls of Fetch and Decode are handled outside this block.
- flush_e=1: the Execute register loads all zeros on that edge and takes priority over the decoded word. Memory and Writeback still advance.

Branch resolution (combinational from Execute): pc_src_e = jump_e | (branch_e & take). take depends on br_cond:
- 000 beq: zero_e.
- 001 bne: !zero_e.
- 100 blt: lt_e.
- 101 bge: !lt_e.
- 110 bltu: ltu_e.
- 111 bgeu: !ltu_e.
- Any other value: 0.

## Timing
- rst_n low: every E/M/W register clears asynchronously, so all _e/_m/_w outputs are 0, including pc_src_e=0, mem_write_m=0 and reg_write_w=0. Release is synchronous to the next rising edge.
- Decode outputs (imm_src_d, illegal_d) have zero latency.
- A control word reaches _e after 1 edge, _m after 2 and _w after 3.
- pc_src_e is valid in the same cycle the instruction occupies Execute.
- flush_e asserted in the same cycle as pc_src_e=1: the current Execute contents still redirect the PC, and the bubble appears on the next edge.
- Reset asserted mid-pipeline: all in-flight writes and stores are dropped immediately.

## Structure
- ctrl_pkg holds:
  - enums alu_ctrl_t (the 10 codes), result_src_t, imm_src_t;
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI;
  - funct3 branch constants;
  - packed struct ctrl_word_t.
- Sub-module instr_decoder (combinational: opcode, funct3, funct7_5 → ctrl_word_t, imm_src, illegal).
- The top level holds the three pipeline registers and the branch logic.

## Test plan
- Reset: hold rst_n=0 with an add in Decode → all _e/_m/_w outputs are 0. Release, then after 3 edges → reg_write_w=1, result_src_w=0.
- Stream lw, sw, sub (funct7_5=1), addi (funct7_5=1) → alu_control_e follows 0, 0, 1, 0; mem_write_m=1 only for the sw slot; result_src_w=1 for the lw slot.
- bne with zero_e=0 → pc_src_e=1. bgeu with ltu_e=1 → pc_src_e=0. blt with lt_e=1 → pc_src_e=1.
- jalr → pc_src_e=1, pc_target_src_e=1, result_src_w=2. lui → imm_src_d=4, result_src_w=3.
- flush_e=1 while sw is decoded → all _e outputs are 0 next cycle, and mem_write_m=0 one cycle later.
- EN_SHIFT=0 with sll (R-type, funct3=001) → illegal_d=1, and the word reaches Writeback as reg_write_w=0.
